// File: rtl/switch_allocator.sv
// switch_allocator: one round-robin arbiter per output port. A port grants a
// single input buffer, holds the grant until that packet's tail flit has been
// transferred, then pulses alloc_clear so route compute can route the next head.
module switch_allocator #(
    parameter int NUM_BUFFERS  = 4,
    parameter int NUM_OUTPORTS = 4,
    parameter int SELECT_SIZE  = $clog2(NUM_OUTPORTS) + (NUM_OUTPORTS == 1),
    parameter int BUF_SEL_SIZE = $clog2(NUM_BUFFERS) + (NUM_BUFFERS == 1)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_BUFFERS-1:0]               i_allocate,
    input  logic [NUM_BUFFERS*SELECT_SIZE-1:0]   i_out_sel,
    input  logic [NUM_BUFFERS-1:0]               i_in_valid,
    input  logic [NUM_BUFFERS-1:0]               i_in_last,
    input  logic [NUM_OUTPORTS-1:0]              i_out_ready,
    output logic [NUM_BUFFERS-1:0]               o_pop,
    output logic [NUM_OUTPORTS-1:0]              o_xbar_valid,
    output logic [NUM_OUTPORTS*BUF_SEL_SIZE-1:0] o_xbar_sel,
    output logic [NUM_BUFFERS-1:0]               o_alloc_clear
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    typedef logic [BUF_SEL_SIZE-1:0] buf_idx_t;

    state_t   r_state      [NUM_OUTPORTS];
    state_t   w_state_nxt  [NUM_OUTPORTS];
    buf_idx_t r_owner      [NUM_OUTPORTS];
    buf_idx_t w_owner_nxt  [NUM_OUTPORTS];
    buf_idx_t r_rr_ptr     [NUM_OUTPORTS];
    buf_idx_t w_rr_ptr_nxt [NUM_OUTPORTS];

    logic [NUM_BUFFERS-1:0] w_owned;
    logic [NUM_BUFFERS-1:0] w_req [NUM_OUTPORTS];

    // First requester at or above ptr, wrapping modulo NUM_BUFFERS.
    function automatic buf_idx_t rr_pick(input logic [NUM_BUFFERS-1:0] req,
                                         input buf_idx_t               ptr);
        buf_idx_t pick;
        logic     found;
        int       idx;
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_BUFFERS; k++) begin
            idx = (int'(ptr) + k) % NUM_BUFFERS;
            if (!found && req[idx]) begin
                pick  = BUF_SEL_SIZE'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // Buffers currently holding a grant on some port must not request again.
    always_comb begin
        w_owned = '0;
        for (int p = 0; p < NUM_OUTPORTS; p++) begin
            if (r_state[p] == ST_BUSY) w_owned[r_owner[p]] = 1'b1;
        end
    end

    // Request matrix; a select at or above NUM_OUTPORTS matches no port.
    always_comb begin
        for (int p = 0; p < NUM_OUTPORTS; p++) begin
            for (int i = 0; i < NUM_BUFFERS; i++) begin
                w_req[p][i] = i_allocate[i] & i_in_valid[i] & ~w_owned[i] &
                              (32'(i_out_sel[i*SELECT_SIZE +: SELECT_SIZE]) == 32'(p));
            end
        end
    end

    // Per-port FSM next state plus the crossbar/pop/clear outputs.
    // NOTE: every output and next-state variable gets a default before the
    // case so no path leaves one unassigned, which would infer a latch.
    always_comb begin
        o_pop         = '0;
        o_xbar_valid  = '0;
        o_xbar_sel    = '0;
        o_alloc_clear = '0;
        for (int p = 0; p < NUM_OUTPORTS; p++) begin
            w_state_nxt[p]  = r_state[p];
            w_owner_nxt[p]  = r_owner[p];
            w_rr_ptr_nxt[p] = r_rr_ptr[p];
            o_xbar_sel[p*BUF_SEL_SIZE +: BUF_SEL_SIZE] = r_owner[p];
            case (r_state[p])
                ST_IDLE: begin
                    // Arbitration cycle: no flit moves, grant takes effect next edge.
                    if (|w_req[p]) begin
                        w_owner_nxt[p] = rr_pick(w_req[p], r_rr_ptr[p]);
                        w_state_nxt[p] = ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    o_xbar_valid[p] = i_in_valid[r_owner[p]] & i_out_ready[p];
                    if (o_xbar_valid[p]) o_pop[r_owner[p]] = 1'b1;
                    if (o_xbar_valid[p] && i_in_last[r_owner[p]]) begin
                        o_alloc_clear[r_owner[p]] = 1'b1;
                        w_state_nxt[p]  = ST_IDLE;
                        w_rr_ptr_nxt[p] = BUF_SEL_SIZE'((int'(r_owner[p]) + 1) % NUM_BUFFERS);
                    end
                end
                default: w_state_nxt[p] = ST_IDLE;
            endcase
        end
    end

    // Port state, owner and round-robin pointer registers.
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int p = 0; p < NUM_OUTPORTS; p++) begin
                r_state[p]  <= ST_IDLE;
                r_owner[p]  <= '0;
                r_rr_ptr[p] <= '0;
            end
        end else begin
            for (int p = 0; p < NUM_OUTPORTS; p++) begin
                r_state[p]  <= w_state_nxt[p];
                r_owner[p]  <= w_owner_nxt[p];
                r_rr_ptr[p] <= w_rr_ptr_nxt[p];
            end
        end
    end

endmodule

// File: tb/tb_switch_allocator.sv
// Bench for switch_allocator: a behavioural model of the ports plus simple
// input-buffer / route-compute stand-ins; expected outputs are queued when the
// cycle's stimulus is driven and compared when the DUT outputs are sampled.
module tb_switch_allocator;

    localparam int NB = 4;
    localparam int NP = 4;
    localparam int SS = 3;   // wide enough to express out_sel = 5
    localparam int BS = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [NB-1:0]    allocate, in_valid, in_last;
    logic [NB*SS-1:0] out_sel;
    logic [NP-1:0]    out_ready;
    logic [NB-1:0]    pop, alloc_clear;
    logic [NP-1:0]    xbar_valid;
    logic [NP*BS-1:0] xbar_sel;

    switch_allocator #(
        .NUM_BUFFERS (NB),
        .NUM_OUTPORTS(NP),
        .SELECT_SIZE (SS),
        .BUF_SEL_SIZE(BS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_allocate   (allocate),
        .i_out_sel    (out_sel),
        .i_in_valid   (in_valid),
        .i_in_last    (in_last),
        .i_out_ready  (out_ready),
        .o_pop        (pop),
        .o_xbar_valid (xbar_valid),
        .o_xbar_sel   (xbar_sel),
        .o_alloc_clear(alloc_clear)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Environment: buffers hold packets of env_len flits, route compute drives allocate.
    bit env_alloc[NB], env_bubble[NB], env_reassert[NB];
    int env_sel[NB], env_rem[NB], env_len[NB], env_pkts[NB];
    bit env_ready[NP];

    // Reference model state.
    bit m_busy[NP], nb_busy[NP];
    int m_owner[NP], nb_owner[NP], m_rr[NP], nb_rr[NP];
    logic [NB-1:0] m_pop, m_clr;

    typedef struct packed {
        logic [NB-1:0]    pop;
        logic [NP-1:0]    xv;
        logic [NB-1:0]    clr;
        logic [NP*BS-1:0] sel;
    } exp_t;
    exp_t sb[$];

    int cyc = 0;
    int pop_log[NB][$];
    int p0_buf[$], p0_cyc[$];

    function automatic bit env_valid(input int i);
        return env_rem[i] > 0 && !env_bubble[i];
    endfunction

    function automatic int q_at(input int q[$], input int idx);
        return (idx < q.size()) ? q[idx] : -1;
    endfunction

    task automatic env_reset();
        for (int i = 0; i < NB; i++) begin
            env_alloc[i] = 0; env_bubble[i] = 0; env_reassert[i] = 0;
            env_sel[i] = 0; env_rem[i] = 0; env_len[i] = 0; env_pkts[i] = 0;
        end
        for (int p = 0; p < NP; p++) env_ready[p] = 1;
    endtask

    task automatic model_reset();
        for (int p = 0; p < NP; p++) begin
            m_busy[p] = 0; m_owner[p] = 0; m_rr[p] = 0;
        end
        m_pop = '0;
        m_clr = '0;
    endtask

    task automatic drive();
        for (int i = 0; i < NB; i++) begin
            allocate[i]          = env_alloc[i];
            out_sel[i*SS +: SS]  = env_sel[i][SS-1:0];
            in_valid[i]          = env_valid(i);
            in_last[i]           = (env_rem[i] == 1);
        end
        for (int p = 0; p < NP; p++) out_ready[p] = env_ready[p];
    endtask

    task automatic model_eval();
        bit   owned[NB];
        exp_t e;
        int   o, i;
        e = '0;
        for (int b = 0; b < NB; b++) owned[b] = 0;
        for (int p = 0; p < NP; p++) if (m_busy[p]) owned[m_owner[p]] = 1;
        for (int p = 0; p < NP; p++) begin
            nb_busy[p] = m_busy[p]; nb_owner[p] = m_owner[p]; nb_rr[p] = m_rr[p];
            if (!m_busy[p]) begin
                for (int k = 0; k < NB; k++) begin
                    i = (m_rr[p] + k) % NB;
                    if (!nb_busy[p] && env_alloc[i] && env_valid(i) && !owned[i] && env_sel[i] == p) begin
                        nb_busy[p]  = 1;
                        nb_owner[p] = i;
                    end
                end
            end else begin
                o = m_owner[p];
                e.sel[p*BS +: BS] = o[BS-1:0];
                if (env_valid(o) && env_ready[p]) begin
                    e.xv[p]  = 1;
                    e.pop[o] = 1;
                    if (env_rem[o] == 1) begin
                        e.clr[o]   = 1;
                        nb_busy[p] = 0;
                        nb_rr[p]   = (o + 1) % NB;
                    end
                end
            end
        end
        m_pop = e.pop;
        m_clr = e.clr;
        sb.push_back(e);
    endtask

    task automatic sample();
        exp_t e;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 1, 0);
            return;
        end
        e = sb.pop_front();
        check($sformatf("pop@%0d", cyc), pop, e.pop);
        check($sformatf("xbar_valid@%0d", cyc), xbar_valid, e.xv);
        check($sformatf("alloc_clear@%0d", cyc), alloc_clear, e.clr);
        for (int p = 0; p < NP; p++) begin
            if (e.xv[p]) check($sformatf("xbar_sel%0d@%0d", p, cyc), xbar_sel[p*BS +: BS], e.sel[p*BS +: BS]);
        end
        for (int i = 0; i < NB; i++) if (pop[i]) pop_log[i].push_back(cyc);
        if (xbar_valid[0]) begin
            p0_buf.push_back(int'(xbar_sel[BS-1:0]));
            p0_cyc.push_back(cyc);
        end
    endtask

    task automatic commit();
        for (int p = 0; p < NP; p++) begin
            m_busy[p] = nb_busy[p]; m_owner[p] = nb_owner[p]; m_rr[p] = nb_rr[p];
        end
        for (int i = 0; i < NB; i++) begin
            if (m_clr[i]) begin
                env_alloc[i]    = 0;
                env_reassert[i] = (env_pkts[i] > 0);
            end else if (env_reassert[i]) begin
                env_alloc[i]    = 1;
                env_reassert[i] = 0;
            end
            if (m_pop[i]) begin
                env_rem[i]--;
                if (env_rem[i] == 0 && env_pkts[i] > 0) begin
                    env_rem[i] = env_len[i];
                    env_pkts[i]--;
                end
            end
        end
    endtask

    task automatic cycle();
        drive();
        model_eval();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
        commit();
        cyc++;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic start_pkt(input int b, input int port, input int len, input int count);
        env_sel[b] = port; env_len[b] = len; env_rem[b] = len;
        env_pkts[b] = count - 1; env_alloc[b] = 1; env_reassert[b] = 0;
    endtask

    task automatic clear_logs();
        for (int i = 0; i < NB; i++) pop_log[i].delete();
        p0_buf.delete();
        p0_cyc.delete();
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_pop"}, pop, 0);
        check({tag, "_xbar_valid"}, xbar_valid, 0);
        check({tag, "_alloc_clear"}, alloc_clear, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s;
        rst = 1'b0;
        env_reset();
        model_reset();
        drive();
        #1 rst = 1'b1;
        #1;
        check_idle_outputs("reset");
        check("reset_xbar_sel", xbar_sel, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Single requester: buffer 2 -> port 1, 3-flit packet.
        clear_logs();
        s = cyc;
        start_pkt(2, 1, 3, 1);
        run(8);
        check("single_npops", pop_log[2].size(), 3);
        for (int k = 0; k < 3; k++) check($sformatf("single_pop%0d", k), q_at(pop_log[2], k), s + 1 + k);

        // Round-robin: buffers 0, 1, 3 contend for port 0 with 1-flit packets.
        clear_logs();
        s = cyc;
        start_pkt(0, 0, 1, 2);
        start_pkt(1, 0, 1, 1);
        start_pkt(3, 0, 1, 1);
        run(12);
        check("rr_order0", q_at(p0_buf, 0), 0);
        check("rr_order1", q_at(p0_buf, 1), 1);
        check("rr_order2", q_at(p0_buf, 2), 3);
        check("rr_order3", q_at(p0_buf, 3), 0);
        for (int k = 0; k < 4; k++) check($sformatf("rr_cycle%0d", k), q_at(p0_cyc, k), s + 1 + 2 * k);

        // Parallel ports: buffer 0 -> port 2, buffer 1 -> port 3.
        clear_logs();
        s = cyc;
        start_pkt(0, 2, 2, 1);
        start_pkt(1, 3, 2, 1);
        run(5);
        check("par_pop0", q_at(pop_log[0], 0), s + 1);
        check("par_pop1", q_at(pop_log[1], 0), s + 1);

        // Backpressure on port 0 while buffer 2 waits behind owner buffer 1.
        clear_logs();
        s = cyc;
        start_pkt(1, 0, 4, 1);
        run(2);
        start_pkt(2, 0, 1, 1);
        env_ready[0] = 0;
        run(4);
        env_ready[0] = 1;
        run(8);
        check("bp_tail_b1", q_at(pop_log[1], 3), s + 8);
        check("bp_first_b2", q_at(pop_log[2], 0), s + 10);

        // Owner bubble on port 1, and a request naming nonexistent port 5.
        clear_logs();
        s = cyc;
        start_pkt(3, 1, 3, 1);
        start_pkt(2, 5, 2, 1);
        run(2);
        env_bubble[3] = 1;
        run(2);
        env_bubble[3] = 0;
        run(5);
        check("bubble_pop0", q_at(pop_log[3], 0), s + 1);
        check("bubble_pop1", q_at(pop_log[3], 1), s + 4);
        check("bubble_pop2", q_at(pop_log[3], 2), s + 5);
        check("badsel_npops", pop_log[2].size(), 0);

        // Asynchronous reset in the middle of a 5-flit packet on port 0.
        clear_logs();
        start_pkt(0, 0, 5, 1);
        run(3);
        #2 rst = 1'b1;
        #1;
        check_idle_outputs("midrst");
        model_reset();
        env_reset();
        sb.delete();
        drive();
        @(posedge clk);
        #1;
        check_idle_outputs("rst_held");
        rst = 1'b0;
        run(3);
        clear_logs();
        s = cyc;
        start_pkt(1, 2, 2, 1);
        run(4);
        check("post_rst_pop0", q_at(pop_log[1], 0), s + 1);
        check("post_rst_pop1", q_at(pop_log[1], 1), s + 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
